// File: rtl/mips_processor_pkg.sv
// Shared definitions for the single-cycle MIPS32 core: opcode/funct codes,
// ALU and next-pc selectors, register-index names and the ALU evaluation helper.
package mips_processor_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_BALRZ = 6'h16;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [4:0] ZERO = 5'd0,  AT = 5'd1,  V0 = 5'd2,  V1 = 5'd3;
   localparam logic [4:0] A0   = 5'd4,  A1 = 5'd5,  A2 = 5'd6,  A3 = 5'd7;
   localparam logic [4:0] T0   = 5'd8,  T1 = 5'd9,  T2 = 5'd10, T3 = 5'd11;
   localparam logic [4:0] T4   = 5'd12, T5 = 5'd13, T6 = 5'd14, T7 = 5'd15;
   localparam logic [4:0] S0   = 5'd16, S1 = 5'd17, S2 = 5'd18, S3 = 5'd19;
   localparam logic [4:0] S4   = 5'd20, S5 = 5'd21, S6 = 5'd22, S7 = 5'd23;
   localparam logic [4:0] T8   = 5'd24, T9 = 5'd25, K0 = 5'd26, K1 = 5'd27;
   localparam logic [4:0] GP   = 5'd28, SP = 5'd29, FP = 5'd30, RA = 5'd31;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG
   } pc_sel_e;

   function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] shamt);
      logic [31:0] res;
      res = '0;
      case (op)
         ALU_ADD: res = a + b;
         ALU_SUB: res = a - b;
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_SLT: res = {31'd0, $signed(a) < $signed(b)};
         ALU_SLL: res = b << shamt;
         ALU_LUI: res = {b[15:0], 16'h0000};
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mips_processor_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// register 0 hard-wired to zero, all registers cleared by asynchronous reset.
module mips_processor_regfile
   import mips_processor_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs_idx,
   input  logic [4:0]  rt_idx,
   input  logic        wr_en,
   input  logic [4:0]  wr_idx,
   input  logic [31:0] wr_data,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_idx != ZERO))
         regs_d[wr_idx] = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         regs_q <= '{default: 32'd0};
      else
         regs_q <= regs_d;
   end

   // Reads see the pre-edge contents, so an instruction may read and write the same register.
   assign rs_data = (rs_idx == ZERO) ? 32'd0 : regs_q[rs_idx];
   assign rt_data = (rt_idx == ZERO) ? 32'd0 : regs_q[rt_idx];

endmodule

// File: rtl/mips_processor.sv
// Single-cycle MIPS32 core with big-endian byte-array instruction and data memories.
// Macro BALRZ_EN enables the balrz instruction (R-type funct 0x16); otherwise it is a NOP.
module mips_processor
   import mips_processor_pkg::*;
#(
   parameter int IMEM_BYTES = 1024,
   parameter int DMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   localparam int IA_W = $clog2(IMEM_BYTES);
   localparam int DA_W = $clog2(DMEM_BYTES);

   logic [7:0]      imem_q [IMEM_BYTES];
   logic [7:0]      dmem_q [DMEM_BYTES];
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     instr_w, pc_plus4, imm_sext, imm_zext, alu_b, alu_res;
   logic [31:0]     load_data, wr_data, rs_data, rt_data;
   logic [5:0]      op, funct;
   logic [4:0]      rs_idx, rt_idx, rd_idx, shamt, wr_idx;
   logic            reg_we, mem_we, mem_re, use_imm, link, zext_imm;
   logic [DA_W-1:0] dmem_addr;
   alu_op_e         alu_op;
   pc_sel_e         pc_sel;

   // Instruction memory is image-loaded from outside before reset release; the core only reads it.
   always_ff @(posedge clk)
      imem_q <= imem_q;

   always_comb begin
      instr_w = '0;
      for (int k = 0; k < 4; k++)
         instr_w = {instr_w[23:0], imem_q[pc_q[IA_W-1:0] + IA_W'(k)]};
   end

   assign op       = instr_w[31:26];
   assign rs_idx   = instr_w[25:21];
   assign rt_idx   = instr_w[20:16];
   assign rd_idx   = instr_w[15:11];
   assign shamt    = instr_w[10:6];
   assign funct    = instr_w[5:0];
   assign imm_sext = {{16{instr_w[15]}}, instr_w[15:0]};
   assign imm_zext = {16'h0000, instr_w[15:0]};
   assign pc_plus4 = pc_q + 32'd4;

   mips_processor_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .rs_idx  (rs_idx),
      .rt_idx  (rt_idx),
      .wr_en   (reg_we),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rs_data (rs_data),
      .rt_data (rt_data)
   );

   // Anything not listed falls through the defaults and retires as a NOP.
   always_comb begin
      reg_we   = 1'b0;
      wr_idx   = rd_idx;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      use_imm  = 1'b0;
      zext_imm = 1'b0;
      link     = 1'b0;
      alu_op   = ALU_ADD;
      pc_sel   = PC_SEQ;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD; end
               FN_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB; end
               FN_AND: begin reg_we = 1'b1; alu_op = ALU_AND; end
               FN_OR:  begin reg_we = 1'b1; alu_op = ALU_OR;  end
               FN_SLT: begin reg_we = 1'b1; alu_op = ALU_SLT; end
               FN_SLL: begin reg_we = 1'b1; alu_op = ALU_SLL; end
               FN_JR:  pc_sel = PC_REG;
`ifdef BALRZ_EN
               FN_BALRZ: begin
                  if (rt_data == 32'd0) begin
                     reg_we = 1'b1;
                     link   = 1'b1;
                     pc_sel = PC_REG;
                  end
               end
`endif
               default: ;
            endcase
         end
         OP_ADDI: begin reg_we = 1'b1; wr_idx = rt_idx; use_imm = 1'b1; end
         OP_ANDI: begin
            reg_we = 1'b1; wr_idx = rt_idx; use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_AND;
         end
         OP_ORI: begin
            reg_we = 1'b1; wr_idx = rt_idx; use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_OR;
         end
         OP_LUI: begin
            reg_we = 1'b1; wr_idx = rt_idx; use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_LUI;
         end
         OP_LW:  begin reg_we = 1'b1; wr_idx = rt_idx; use_imm = 1'b1; mem_re = 1'b1; end
         OP_SW:  begin mem_we = 1'b1; use_imm = 1'b1; end
         OP_BEQ: if (rs_data == rt_data) pc_sel = PC_BRANCH;
         OP_BNE: if (rs_data != rt_data) pc_sel = PC_BRANCH;
         OP_J:   pc_sel = PC_JUMP;
         OP_JAL: begin pc_sel = PC_JUMP; reg_we = 1'b1; wr_idx = RA; link = 1'b1; end
         default: ;
      endcase
   end

   assign alu_b     = use_imm ? (zext_imm ? imm_zext : imm_sext) : rt_data;
   assign alu_res   = alu_eval(alu_op, rs_data, alu_b, shamt);
   assign dmem_addr = alu_res[DA_W-1:0];

   always_comb begin
      load_data = '0;
      for (int k = 0; k < 4; k++)
         load_data = {load_data[23:0], dmem_q[dmem_addr + DA_W'(k)]};
   end

   assign wr_data = link ? pc_plus4 : (mem_re ? load_data : alu_res);

   // Data memory is not cleared by reset, and a store seen while in reset must not land.
   always_ff @(posedge clk) begin
      if (mem_we && rst_n) begin
         for (int k = 0; k < 4; k++)
            dmem_q[dmem_addr + DA_W'(k)] <= rt_data[31-8*k -: 8];
      end
   end

   always_comb begin
      pc_d = pc_plus4;
      case (pc_sel)
         PC_BRANCH: pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
         PC_JUMP:   pc_d = {pc_plus4[31:28], instr_w[25:0], 2'b00};
         PC_REG:    pc_d = rs_data;
         default:   pc_d = pc_plus4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_q <= 32'd0;
      else
         pc_q <= pc_d;
   end

   assign pc    = pc_q;
   assign instr = instr_w;

endmodule

// File: tb/tb_mips_processor.sv
// Bench for mips_processor: directed program for the called-out cases, then a random
// program checked cycle by cycle against an instruction-level interpreter.
module tb_mips_processor;

   localparam int IMEM_BYTES  = 1024;
   localparam int DMEM_BYTES  = 1024;
   localparam int RAND_INSTRS = 160;
   localparam int RAND_CYCLES = 400;

   localparam logic [4:0] R_ZERO = 5'd0,  R_A0 = 5'd4,  R_A1 = 5'd5,  R_T0 = 5'd8;
   localparam logic [4:0] R_T1   = 5'd9,  R_T2 = 5'd10, R_T3 = 5'd11, R_T4 = 5'd12;
   localparam logic [4:0] R_T5   = 5'd13, R_S0 = 5'd16, R_RA = 5'd31;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic [31:0] instr;

   int checks = 0;
   int errors = 0;

   logic [7:0]  prog   [IMEM_BYTES];
   logic [31:0] m_regs [32];
   logic [7:0]  m_dmem [DMEM_BYTES];
   logic [31:0] m_pc;
   logic [31:0] exp_q[$];
   logic [31:0] exp_instr_q[$];

   mips_processor #(.IMEM_BYTES(IMEM_BYTES), .DMEM_BYTES(DMEM_BYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pc    (pc),
      .instr (instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gpr(input int i);
      return dut.u_regfile.regs_q[i];
   endfunction

   function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] target);
      return {op, target[27:2]};
   endfunction

   task automatic put_word(input int a, input logic [31:0] w);
      for (int k = 0; k < 4; k++)
         prog[(a + k) % IMEM_BYTES] = w[31-8*k -: 8];
   endtask

   task automatic clear_prog();
      for (int i = 0; i < IMEM_BYTES; i++)
         prog[i] = 8'h00;
   endtask

   task automatic load_dut();
      for (int i = 0; i < IMEM_BYTES; i++)
         dut.imem_q[i] = prog[i];
   endtask

   function automatic logic [31:0] fetch(input logic [31:0] a);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++)
         w = {w[23:0], prog[(a + k) % IMEM_BYTES]};
      return w;
   endfunction

   // Reference interpreter: executes one instruction on the architectural state.
   task automatic model_step();
      logic [31:0] w, a, b, se, ze, nxt, val, ea;
      int wr;
      w   = fetch(m_pc);
      a   = m_regs[w[25:21]];
      b   = m_regs[w[20:16]];
      se  = {{16{w[15]}}, w[15:0]};
      ze  = {16'h0000, w[15:0]};
      ea  = a + se;
      nxt = m_pc + 4;
      wr  = -1;
      val = '0;
      case (w[31:26])
         6'h00: case (w[5:0])
            6'h20: begin wr = w[15:11]; val = a + b; end
            6'h22: begin wr = w[15:11]; val = a - b; end
            6'h24: begin wr = w[15:11]; val = a & b; end
            6'h25: begin wr = w[15:11]; val = a | b; end
            6'h2A: begin wr = w[15:11]; val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            6'h00: begin wr = w[15:11]; val = b << w[10:6]; end
            6'h08: nxt = a;
`ifdef BALRZ_EN
            6'h16: if (b == 32'd0) begin wr = w[15:11]; val = m_pc + 4; nxt = a; end
`endif
            default: ;
         endcase
         6'h08: begin wr = w[20:16]; val = ea; end
         6'h0C: begin wr = w[20:16]; val = a & ze; end
         6'h0D: begin wr = w[20:16]; val = a | ze; end
         6'h0F: begin wr = w[20:16]; val = {w[15:0], 16'h0000}; end
         6'h23: begin
            wr = w[20:16];
            for (int k = 0; k < 4; k++)
               val = {val[23:0], m_dmem[(ea + k) % DMEM_BYTES]};
         end
         6'h2B: for (int k = 0; k < 4; k++) m_dmem[(ea + k) % DMEM_BYTES] = b[31-8*k -: 8];
         6'h04: if (a == b) nxt = m_pc + 4 + (se << 2);
         6'h05: if (a != b) nxt = m_pc + 4 + (se << 2);
         6'h02: nxt = {nxt[31:28], w[25:0], 2'b00};
         6'h03: begin wr = 31; val = m_pc + 4; nxt = {nxt[31:28], w[25:0], 2'b00}; end
         default: ;
      endcase
      if (wr > 0) m_regs[wr] = val;
      m_pc = nxt;
   endtask

   function automatic logic [4:0] rr();
      return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
   endfunction

   function automatic logic [5:0] alu_fn();
      case ($urandom_range(0, 5))
         0: return 6'h20;
         1: return 6'h22;
         2: return 6'h24;
         3: return 6'h25;
         4: return 6'h2A;
         default: return 6'h00;
      endcase
   endfunction

   function automatic logic [5:0] imm_op();
      case ($urandom_range(0, 3))
         0: return 6'h08;
         1: return 6'h0C;
         2: return 6'h0D;
         default: return 6'h0F;
      endcase
   endfunction

   // Prologue zeroes the data window that random loads/stores use.
   task automatic gen_prog(input int n);
      int a;
      clear_prog();
      for (int k = 0; k < 16; k++)
         put_word(4 * k, i_ins(6'h2B, R_ZERO, R_ZERO, 16'(4 * k)));
      for (int i = 0; i < n; i++) begin
         a = 64 + 4 * i;
         case ($urandom_range(0, 9))
            0: put_word(a, r_ins(alu_fn(), rr(), rr(), rr(), 5'($urandom_range(0, 31))));
            1, 2: put_word(a, i_ins(imm_op(), rr(), rr(), 16'($urandom)));
            3: put_word(a, i_ins(6'h23, R_ZERO, rr(), 16'(4 * $urandom_range(0, 15))));
            4: put_word(a, i_ins(6'h2B, R_ZERO, rr(), 16'(4 * $urandom_range(0, 15))));
            5: put_word(a, i_ins($urandom_range(0, 1) ? 6'h04 : 6'h05, rr(), rr(),
                                 16'($urandom_range(0, 3))));
            6: put_word(a, j_ins($urandom_range(0, 1) ? 6'h03 : 6'h02,
                                 32'(a + 4 * $urandom_range(1, 4))));
            7: put_word(a, r_ins(6'h08, rr(), R_ZERO, R_ZERO, 5'd0));
            8: put_word(a, r_ins(6'h16, rr(), rr(), rr(), 5'd0));
            default: put_word(a, $urandom_range(0, 1) ? {6'h3F, 26'($urandom)}
                                                      : r_ins(6'h3F, rr(), rr(), rr(), 5'd0));
         endcase
      end
   endtask

   initial begin
      logic [31:0] word0;
      rst_n = 1'b0;

      // Directed program
      clear_prog();
      put_word(32'h00, i_ins(6'h08, R_ZERO, R_S0, 16'd4));
      put_word(32'h04, i_ins(6'h08, R_ZERO, R_A1, 16'd2));
      put_word(32'h08, i_ins(6'h08, R_ZERO, R_T2, 16'h0020));
      put_word(32'h0C, r_ins(6'h16, R_T2, R_A1, R_A0, 5'd0));
      put_word(32'h10, r_ins(6'h16, R_T2, R_ZERO, R_A0, 5'd0));
      put_word(32'h14, i_ins(6'h08, R_ZERO, R_T3, 16'd7));
      put_word(32'h20, i_ins(6'h2B, R_ZERO, R_S0, 16'd8));
      put_word(32'h24, i_ins(6'h23, R_ZERO, R_T1, 16'd8));
      put_word(32'h28, i_ins(6'h04, R_ZERO, R_ZERO, 16'd1));
      put_word(32'h2C, i_ins(6'h08, R_ZERO, R_T4, 16'd9));
      put_word(32'h30, i_ins(6'h08, R_ZERO, R_ZERO, 16'd5));
      put_word(32'h34, j_ins(6'h02, 32'h40));
      put_word(32'h38, i_ins(6'h08, R_ZERO, R_T5, 16'd1));
      put_word(32'h40, j_ins(6'h03, 32'h50));
      put_word(32'h44, i_ins(6'h08, R_ZERO, R_T5, 16'd2));
      put_word(32'h50, r_ins(6'h16, R_RA, R_ZERO, R_ZERO, 5'd0));
      word0 = fetch(32'h0);
      load_dut();

      #2;
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, word0);
      check("rst_s0", gpr(R_S0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      tick();
      check("addi_s0", gpr(R_S0), 32'd4);
      check("addi_t0", gpr(R_T0), 32'd0);
      check("pc_4", pc, 32'h04);
      tick();
      tick();
      tick();
      check("balrz_nt_pc", pc, 32'h10);
      check("balrz_nt_a0", gpr(R_A0), 32'd0);
      check("balrz_nt_a1", gpr(R_A1), 32'd2);
      tick();
`ifdef BALRZ_EN
      check("balrz_t_pc", pc, 32'h20);
      check("balrz_t_a0", gpr(R_A0), 32'h14);
`else
      check("balrz_off_pc", pc, 32'h14);
      check("balrz_off_a0", gpr(R_A0), 32'd0);
      repeat (3) tick();
      check("balrz_off_t3", gpr(R_T3), 32'd7);
`endif
      check("pc_at_sw", pc, 32'h20);
      tick();
      tick();
      check("lw_t1", gpr(R_T1), 32'd4);
      tick();
      check("beq_pc", pc, 32'h30);
      tick();
      check("zero_reg", gpr(R_ZERO), 32'd0);
      tick();
      check("j_pc", pc, 32'h40);
      tick();
      check("jal_pc", pc, 32'h50);
      check("jal_ra", gpr(R_RA), 32'h44);
      check("skip_t4", gpr(R_T4), 32'd0);
      check("skip_t5", gpr(R_T5), 32'd0);
`ifdef BALRZ_EN
      check("no_slot_t3", gpr(R_T3), 32'd0);
`endif
      tick();
`ifdef BALRZ_EN
      check("balrz_rd0_pc", pc, 32'h44);
`else
      check("balrz_rd0_pc", pc, 32'h54);
`endif
      check("balrz_rd0_zero", gpr(R_ZERO), 32'd0);

      // Asynchronous reset between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      check("async_pc", pc, 32'h0);
      check("async_instr", instr, word0);
      check("async_s0", gpr(R_S0), 32'd0);
      check("async_ra", gpr(R_RA), 32'd0);

      // Random program against the interpreter
      gen_prog(RAND_INSTRS);
      load_dut();
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      for (int i = 0; i < DMEM_BYTES; i++) m_dmem[i] = 8'h00;
      for (int c = 0; c < RAND_CYCLES; c++) begin
         exp_instr_q.push_back(fetch(m_pc));
         model_step();
         exp_q.push_back(m_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      while (exp_q.size() > 0) begin
         check("rand_instr", instr, exp_instr_q.pop_front());
         tick();
         check("rand_pc", pc, exp_q.pop_front());
      end
      for (int i = 0; i < 32; i++)
         check($sformatf("rand_reg%0d", i), gpr(i), m_regs[i]);
      for (int i = 0; i < 64; i++)
         check($sformatf("rand_mem%0d", i), {24'h0, dut.dmem_q[i]}, {24'h0, m_dmem[i]});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_processor.md
MIPS_PROCESSOR -- requirements
Module: mips_processor

Interface
REQ-001 Parameter IMEM_BYTES, default 1024, instruction memory size in bytes.
REQ-002 Parameter DMEM_BYTES, default 1024, data memory size in bytes.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc  output  32  current program counter (debug).
REQ-006 instr  output  32  instruction currently executing (debug).

Function
REQ-007 The block SHALL be a single-cycle MIPS32 core: one instruction fetched, executed and retired per clk rising edge.
REQ-008 Instruction memory SHALL be a byte array; the instruction word is big-endian (byte at pc is bits 31:24); memory is loaded by the bench before reset release.
REQ-009 Data memory SHALL be a big-endian byte array; writes are synchronous; reads are combinational.
REQ-010 Register file SHALL hold 32x32 registers with two combinational read ports and one synchronous write port; register 0 always reads 0 and ignores writes.
REQ-011 Supported R-type (opcode 0) by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, jr 0x08; rd written except for jr.
REQ-012 Supported I/J-type: addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
REQ-013 addi, lw and sw SHALL sign-extend imm16; andi and ori SHALL zero-extend it; arithmetic wraps modulo 2^32 with no overflow trap.
REQ-014 Branch target SHALL be pc+4+(sext(imm16)<<2); jump target SHALL be {pc+4[31:28], imm26, 2'b00}; jal SHALL write pc+4 to $31.
REQ-015 No delay slots: the instruction after a taken branch or jump SHALL NOT execute.
REQ-016 balrz (R-type, funct 0x16, fields rs, rt, rd): if GPR[rt]==0, write pc+4 to GPR[rd] and set next pc to GPR[rs]; otherwise neither GPR[rd] nor pc+4 flow changes (next pc = pc+4).
REQ-017 balrz with rd==0 SHALL still jump when taken; the link write is discarded.
REQ-018 Undefined opcodes or functs SHALL execute as NOP: no register or memory write, next pc = pc+4.
REQ-019 pc SHALL wrap modulo IMEM_BYTES when fetching; lw/sw addresses SHALL use the low log2(DMEM_BYTES) bits.
REQ-020 When an instruction reads and writes the same register, reads return the pre-edge value.

Reset
REQ-021 While rst_n is low: pc=0, all 32 registers=0, instr reflects the word at address 0; memories are not cleared.
REQ-022 Reset asserted mid-program SHALL take effect immediately (asynchronous); first instruction after release is at address 0.

Configuration
REQ-023 Macro BALRZ_EN: when defined, balrz is decoded per REQ-016; when undefined, funct 0x16 decodes as NOP per REQ-018.

Structure
REQ-024 A shared package SHALL hold opcode and funct constants, ALU-control encodings and register-index names (ZERO, T0, S0, A0, A1, RA, ...).
REQ-025 Sub-modules: regfile (register file) is required; fetch unit (pc plus instruction memory), decoder/control, ALU and data memory may be separate modules.

Verification
REQ-026 Reset then addi $s0,$0,4 -> after first clk, $s0=4 and $t0=0.
REQ-027 balrz with GPR[rt]=0, rs holding target 0x20, rd=$a0 at pc 0x10 -> $a0=0x14, next pc=0x20; instruction at 0x14 does not execute.
REQ-028 balrz with GPR[rt]=2 -> $a0 unchanged (0), $a1=2 unchanged, pc advances by 4.
REQ-029 sw $s0 to address 8, then lw $t1 from 8 -> $t1=4; beq taken over a write -> skipped register remains 0.
REQ-030 addi $0,$0,5 -> $0 reads 0; jal at 0x40 -> $ra=0x44.
REQ-031 Build without BALRZ_EN, run balrz with GPR[rt]=0 -> no link write, pc+4.
